sepia_stream_filter: RTL

- Consumes the R/G/B pixel stream produced by the image read stage, one pixel per beat in raster order (top row first, left to right, after that stage's bottom-up row reversal).
- Applies a fixed-point sepia transform in a 3-stage pipeline with valid/ready flow control.
- Tags output pixels with start-of-frame, end-of-line and end-of-frame markers for the downstream image writer.

---
 rtl/sepia_stream_filter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sepia_stream_filter.sv
// Sepia tone filter for a raster R/G/B pixel stream.
// Three-stage pipeline (products, sums, shift/saturate) with valid/ready flow
// control. Each pixel carries start-of-frame, end-of-line and end-of-frame tags.
module sepia_stream_filter #(
  parameter int unsigned WIDTH  = 500,
  parameter int unsigned HEIGHT = 333,
  parameter int unsigned DATA_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_bypass,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_r,
  output logic [DATA_W-1:0] o_g,
  output logic [DATA_W-1:0] o_b,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof
);

  localparam int unsigned PROD_W = DATA_W + 8;
  localparam int unsigned SUM_W  = DATA_W + 10;
  localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  // Row-major coefficient matrix: {R', G', B'} x {R, G, B}.
  localparam logic [7:0] COEF [9] = '{8'd101, 8'd197, 8'd48,
                                      8'd89,  8'd176, 8'd43,
                                      8'd70,  8'd137, 8'd34};

  logic              advance;
  logic              accept;
  logic [COL_W-1:0]  colCnt;
  logic [ROW_W-1:0]  rowCnt;
  logic              colLast;
  logic              rowLast;
  logic [DATA_W-1:0] inPix [3];
  logic [PROD_W-1:0] prod [9];

  logic              s1Valid, s1Bypass, s1Sof, s1Eol, s1Eof;
  logic [DATA_W-1:0] s1R, s1G, s1B;
  logic [PROD_W-1:0] s1Prod [9];

  logic              s2Valid, s2Bypass, s2Sof, s2Eol, s2Eof;
  logic [DATA_W-1:0] s2R, s2G, s2B;
  logic [SUM_W-1:0]  s2SumR, s2SumG, s2SumB;

  // Divide by 256 and clamp to the component range.
  function automatic logic [DATA_W-1:0] satShift(input logic [SUM_W-1:0] s);
    logic [SUM_W-9:0] sh;
    sh = s[SUM_W-1:8];
    if (|sh[SUM_W-9:DATA_W]) return '1;
    return sh[DATA_W-1:0];
  endfunction

  assign advance = !o_valid || o_ready;
  assign i_ready = advance;
  assign accept  = i_valid && advance;
  assign colLast = (colCnt == COL_W'(WIDTH - 1));
  assign rowLast = (rowCnt == ROW_W'(HEIGHT - 1));

  // Nine coefficient products from the incoming pixel.
  always_comb begin
    inPix[0] = i_r;
    inPix[1] = i_g;
    inPix[2] = i_b;
    for (int k = 0; k < 9; k++) begin
      prod[k] = PROD_W'(inPix[k % 3]) * PROD_W'(COEF[k]);
    end
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      colCnt <= '0;
      rowCnt <= '0;
    end else if (accept) begin
      if (colLast) begin
        colCnt <= '0;
        rowCnt <= rowLast ? '0 : rowCnt + 1'b1;
      end else begin
        colCnt <= colCnt + 1'b1;
      end
    end
  end

  // Stage 1: register products, raw pixel and tags; bubbles get cleared tags.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1Valid  <= 1'b0;
      s1Bypass <= 1'b0;
      s1Sof    <= 1'b0;
      s1Eol    <= 1'b0;
      s1Eof    <= 1'b0;
      s1R      <= '0;
      s1G      <= '0;
      s1B      <= '0;
      for (int k = 0; k < 9; k++) s1Prod[k] <= '0;
    end else if (advance) begin
      s1Valid  <= accept;
      s1Bypass <= i_bypass;
      s1Sof    <= accept && (colCnt == '0) && (rowCnt == '0);
      s1Eol    <= accept && colLast;
      s1Eof    <= accept && colLast && rowLast;
      s1R      <= i_r;
      s1G      <= i_g;
      s1B      <= i_b;
      for (int k = 0; k < 9; k++) s1Prod[k] <= prod[k];
    end
  end

  // Stage 2: sum the products per output channel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s2Valid  <= 1'b0;
      s2Bypass <= 1'b0;
      s2Sof    <= 1'b0;
      s2Eol    <= 1'b0;
      s2Eof    <= 1'b0;
      s2R      <= '0;
      s2G      <= '0;
      s2B      <= '0;
      s2SumR   <= '0;
      s2SumG   <= '0;
      s2SumB   <= '0;
    end else if (advance) begin
      s2Valid  <= s1Valid;
      s2Bypass <= s1Bypass;
      s2Sof    <= s1Sof;
      s2Eol    <= s1Eol;
      s2Eof    <= s1Eof;
      s2R      <= s1R;
      s2G      <= s1G;
      s2B      <= s1B;
      s2SumR   <= SUM_W'(s1Prod[0]) + SUM_W'(s1Prod[1]) + SUM_W'(s1Prod[2]);
      s2SumG   <= SUM_W'(s1Prod[3]) + SUM_W'(s1Prod[4]) + SUM_W'(s1Prod[5]);
      s2SumB   <= SUM_W'(s1Prod[6]) + SUM_W'(s1Prod[7]) + SUM_W'(s1Prod[8]);
    end
  end

  // Stage 3: output register, shift/saturate or pass the original pixel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
    end else if (advance) begin
      o_valid <= s2Valid;
      o_sof   <= s2Sof;
      o_eol   <= s2Eol;
      o_eof   <= s2Eof;
      o_r     <= s2Bypass ? s2R : satShift(s2SumR);
      o_g     <= s2Bypass ? s2G : satShift(s2SumG);
      o_b     <= s2Bypass ? s2B : satShift(s2SumB);
    end
  end

endmodule
